// File: rtl/pmem_arbiter.sv
// Physical-memory port arbiter shared by the instruction and data caches.
// One requester is served at a time, with round-robin on ties. Address and
// write data are registered toward memory. The memory response is steered
// back to the granted cache. A single turnaround cycle follows every
// transaction so that a request still held from the finished transfer is
// never granted again.
module pmem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_pmem_read,
    input  logic [ADDR_WIDTH-1:0] i_pmem_address,
    output logic [LINE_WIDTH-1:0] i_pmem_rdata,
    output logic                  i_pmem_resp,
    input  logic                  d_pmem_read,
    input  logic                  d_pmem_write,
    input  logic [ADDR_WIDTH-1:0] d_pmem_address,
    input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
    output logic [LINE_WIDTH-1:0] d_pmem_rdata,
    output logic                  d_pmem_resp,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [LINE_WIDTH-1:0] mem_wdata,
    input  logic [LINE_WIDTH-1:0] mem_rdata,
    input  logic                  mem_resp
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        TURN    = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LINE_WIDTH-1:0] wdata_q, wdata_d;
    logic                  is_write_q, is_write_d;
    logic                  last_grant_q, last_grant_d;   // 0 = icache, 1 = dcache
    logic [LINE_WIDTH-1:0] i_rdata_q, i_rdata_d;         // last line handed to icache
    logic [LINE_WIDTH-1:0] d_rdata_q, d_rdata_d;         // last line handed to dcache
    logic                  req_i, req_d;

    // State and datapath registers; reset abandons any in-flight transfer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            is_write_q   <= 1'b0;
            last_grant_q <= 1'b1;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            is_write_q   <= is_write_d;
            last_grant_q <= last_grant_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    // Arbitration, memory command generation and response steering.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        is_write_d   = is_write_q;
        last_grant_d = last_grant_q;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        mem_address  = addr_q;
        mem_wdata    = wdata_q;
        i_pmem_resp  = 1'b0;
        d_pmem_resp  = 1'b0;
        req_i        = i_pmem_read;
        req_d        = d_pmem_read | d_pmem_write;

        case (state_q)
            IDLE: begin
                // On a tie the icache wins only if the dcache had the last grant.
                if (req_i && (!req_d || last_grant_q)) begin
                    state_d      = SERVE_I;
                    addr_d       = i_pmem_address;
                    is_write_d   = 1'b0;
                    last_grant_d = 1'b0;
                end else if (req_d) begin
                    state_d      = SERVE_D;
                    addr_d       = d_pmem_address;
                    wdata_d      = d_pmem_wdata;
                    is_write_d   = d_pmem_write;   // write wins if both are raised
                    last_grant_d = 1'b1;
                end
            end
            SERVE_I: begin
                mem_read  = ~is_write_q;
                mem_write = is_write_q;
                if (mem_resp) begin
                    i_pmem_resp = 1'b1;
                    state_d     = TURN;
                end
            end
            SERVE_D: begin
                mem_read  = ~is_write_q;
                mem_write = is_write_q;
                if (mem_resp) begin
                    d_pmem_resp = 1'b1;
                    state_d     = TURN;
                end
            end
            TURN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // The completing cache sees memory data directly; the other keeps its shadow.
        i_pmem_rdata = i_pmem_resp ? mem_rdata : i_rdata_q;
        d_pmem_rdata = d_pmem_resp ? mem_rdata : d_rdata_q;
        i_rdata_d    = i_pmem_rdata;
        d_rdata_d    = d_pmem_rdata;
    end

endmodule

// File: tb/tb_pmem_arbiter.sv
// Randomized bench for pmem_arbiter: two cache agents and a memory agent
// drive the block, and a transaction-level model predicts every output.
module tb_pmem_arbiter;

    localparam int AW = 32;
    localparam int LW = 256;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          i_pmem_read = 1'b0;
    logic [AW-1:0] i_pmem_address = '0;
    logic [LW-1:0] i_pmem_rdata;
    logic          i_pmem_resp;
    logic          d_pmem_read = 1'b0;
    logic          d_pmem_write = 1'b0;
    logic [AW-1:0] d_pmem_address = '0;
    logic [LW-1:0] d_pmem_wdata = '0;
    logic [LW-1:0] d_pmem_rdata;
    logic          d_pmem_resp;
    logic          mem_read;
    logic          mem_write;
    logic [AW-1:0] mem_address;
    logic [LW-1:0] mem_wdata;
    logic [LW-1:0] mem_rdata = '0;
    logic          mem_resp = 1'b0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pmem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_pmem_read    (i_pmem_read),
        .i_pmem_address (i_pmem_address),
        .i_pmem_rdata   (i_pmem_rdata),
        .i_pmem_resp    (i_pmem_resp),
        .d_pmem_read    (d_pmem_read),
        .d_pmem_write   (d_pmem_write),
        .d_pmem_address (d_pmem_address),
        .d_pmem_wdata   (d_pmem_wdata),
        .d_pmem_rdata   (d_pmem_rdata),
        .d_pmem_resp    (d_pmem_resp),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_address    (mem_address),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .mem_resp       (mem_resp)
    );

    task automatic check_val(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Transaction-level reference: one open transfer, a turnaround flag,
    // the round-robin preference and each cache's last delivered line.
    bit          txn_open;
    int          txn_who;      // 0 = icache, 1 = dcache
    bit          txn_wr;
    logic [AW-1:0] txn_addr;
    logic [LW-1:0] txn_data;
    bit          cooling;
    bit          prefer_i;
    logic [LW-1:0] last_line [2];

    // Cache agent bookkeeping
    int i_idle_cnt, d_idle_cnt;

    function automatic logic [LW-1:0] rnd_line();
        logic [LW-1:0] v;
        for (int k = 0; k < LW / 32; k++) v[k*32 +: 32] = $urandom();
        return v;
    endfunction

    task automatic model_reset();
        txn_open     = 1'b0;
        cooling      = 1'b0;
        prefer_i     = 1'b1;
        last_line[0] = '0;
        last_line[1] = '0;
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_mem_read"},  mem_read, 0);
        check_val({tag, "_mem_write"}, mem_write, 0);
        check_val({tag, "_i_resp"},    i_pmem_resp, 0);
        check_val({tag, "_d_resp"},    d_pmem_resp, 0);
        check_val({tag, "_i_rdata"},   i_pmem_rdata, 0);
        check_val({tag, "_d_rdata"},   d_pmem_rdata, 0);
        check_val({tag, "_mem_addr"},  mem_address, 0);
    endtask

    initial begin
        bit       exp_i_resp, exp_d_resp;
        bit       want_i, want_d;
        logic [LW-1:0] exp_i_rdata, exp_d_rdata;

        model_reset();
        i_idle_cnt = 0;
        d_idle_cnt = 0;

        // Reset asserted with both caches requesting: everything quiet.
        i_pmem_read    = 1'b1;
        i_pmem_address = 32'h0000_1000;
        d_pmem_read    = 1'b1;
        d_pmem_address = 32'h0000_2000;
        repeat (3) @(negedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b1;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc != 0) @(negedge clk);

            // Occasional reset landing between clock edges, often mid-transfer.
            if (cyc % 600 == 300) begin
                #2 rst = 1'b0;
                #1 check_all_zero("async_rst");
                model_reset();
                mem_resp = 1'b1;
                @(posedge clk);
                #1 check_all_zero("rst_hold");
                @(negedge clk);
                rst = 1'b1;
            end

            // icache agent: requests a line read, may wander its address.
            if (cyc != 0) begin
                if (i_idle_cnt > 0) begin
                    i_idle_cnt--;
                    i_pmem_read = 1'b0;
                end else if (!i_pmem_read) begin
                    if ($urandom_range(0, 2) == 0) begin
                        i_pmem_read    = 1'b1;
                        i_pmem_address = {$urandom_range(0, 32'hFFFF), 5'b0};
                    end
                end else begin
                    if ($urandom_range(0, 4) == 0) i_pmem_address = {$urandom_range(0, 32'hFFFF), 5'b0};
                    if ($urandom_range(0, 39) == 0) i_pmem_read = 1'b0;
                end

                // dcache agent: reads or writebacks, rarely both strobes at once.
                if (d_idle_cnt > 0) begin
                    d_idle_cnt--;
                    d_pmem_read  = 1'b0;
                    d_pmem_write = 1'b0;
                end else if (!(d_pmem_read | d_pmem_write)) begin
                    if ($urandom_range(0, 2) == 0) begin
                        d_pmem_write   = $urandom_range(0, 1);
                        d_pmem_read    = ~d_pmem_write | ($urandom_range(0, 15) == 0);
                        d_pmem_address = {$urandom(), 5'b0} | 32'h8000_0000;
                        d_pmem_wdata   = rnd_line();
                    end
                end else begin
                    if ($urandom_range(0, 4) == 0) d_pmem_address = $urandom();
                    if ($urandom_range(0, 4) == 0) d_pmem_wdata = rnd_line();
                    if ($urandom_range(0, 39) == 0) begin
                        d_pmem_read  = 1'b0;
                        d_pmem_write = 1'b0;
                    end
                end
            end

            // Memory agent: completes an open transfer after a random wait,
            // and sometimes pulses a stray response when nothing is open.
            mem_resp  = txn_open ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
            mem_rdata = rnd_line();
            #1;

            // Predicted outputs for this cycle
            exp_i_resp  = txn_open && mem_resp && (txn_who == 0);
            exp_d_resp  = txn_open && mem_resp && (txn_who == 1);
            exp_i_rdata = exp_i_resp ? mem_rdata : last_line[0];
            exp_d_rdata = exp_d_resp ? mem_rdata : last_line[1];

            check_val("mem_read",  mem_read,  txn_open && !txn_wr);
            check_val("mem_write", mem_write, txn_open && txn_wr);
            check_val("i_resp",    i_pmem_resp, exp_i_resp);
            check_val("d_resp",    d_pmem_resp, exp_d_resp);
            check_val("i_rdata",   i_pmem_rdata, exp_i_rdata);
            check_val("d_rdata",   d_pmem_rdata, exp_d_rdata);
            if (txn_open) check_val("mem_addr", mem_address, txn_addr);
            if (txn_open && txn_wr) check_val("mem_wdata", mem_wdata, txn_data);
            if (cyc == 1) check_val("first_tie_icache_addr", mem_address, 32'h0000_1000);

            // Advance the model across the coming rising edge.
            if (txn_open) begin
                if (mem_resp) begin
                    last_line[txn_who] = mem_rdata;
                    txn_open = 1'b0;
                    cooling  = 1'b1;
                end
            end else if (cooling) begin
                cooling = 1'b0;
            end else begin
                want_i = i_pmem_read;
                want_d = d_pmem_read | d_pmem_write;
                if (want_i && (!want_d || prefer_i)) begin
                    txn_open = 1'b1;
                    txn_who  = 0;
                    txn_wr   = 1'b0;
                    txn_addr = i_pmem_address;
                    prefer_i = 1'b0;
                end else if (want_d) begin
                    txn_open = 1'b1;
                    txn_who  = 1;
                    txn_wr   = d_pmem_write;
                    txn_addr = d_pmem_address;
                    txn_data = d_pmem_wdata;
                    prefer_i = 1'b1;
                end
            end

            // A cache that got its response backs off for a few cycles.
            if (exp_i_resp) begin
                i_idle_cnt  = $urandom_range(1, 3);
                i_pmem_read = 1'b0;
            end
            if (exp_d_resp) begin
                d_idle_cnt   = $urandom_range(1, 3);
                d_pmem_read  = 1'b0;
                d_pmem_write = 1'b0;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
